// File: rtl/mult_datapath.sv
// Repeated-addition multiplier datapath: holds A, counts B down, accumulates A into P,
// and hands the finished product to a valid/ready consumer with a sticky overwrite flag.
module mult_datapath #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 ld_a,
    input  logic                 ld_b,
    input  logic                 ld_p,
    input  logic                 clr,
    input  logic                 dec,
    output logic                 eqz,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 ovr
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [PW-1:0]    p_q;
    logic [PW-1:0]    p_d;
    logic             b_nz;
    logic             done;
    logic             xfer;
    logic             busy_d;
    logic             valid_d;
    logic             ovr_d;

    assign b_nz = (b_q != '0);
    // eqz decodes the registered counter only; no input reaches it combinationally
    assign eqz  = ~b_nz;

    // Done fires when the armed operation takes its last (or only) decrement
    always_comb begin
        done = busy & dec & (b_q <= WIDTH'(1));
        xfer = res_valid & res_ready;
    end

    // B counter: load wins over decrement, and it saturates at zero
    always_comb begin
        b_d = b_q;
        if (ld_b) begin
            b_d = data_in;
        end else if (dec && b_nz) begin
            b_d = b_q - WIDTH'(1);
        end
    end

    // P accumulator: clear wins; adds at B == 0 are dropped to guard against controller overrun
    always_comb begin
        p_d = p_q;
        if (clr) begin
            p_d = '0;
        end else if (ld_p && b_nz) begin
            p_d = p_q + PW'(a_q);
        end
    end

    // Armed flag, result-valid and overwrite flag next-state
    always_comb begin
        busy_d  = busy;
        valid_d = res_valid;
        ovr_d   = ovr;
        if (done) begin
            busy_d = 1'b0;
        end
        if (ld_b) begin
            busy_d = 1'b1;
        end
        if (done) begin
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        if (clr) begin
            ovr_d = 1'b0;
        end
        if (done && res_valid && !res_ready) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            ovr       <= 1'b0;
        end else begin
            if (ld_a) begin
                a_q <= data_in;
            end
            b_q       <= b_d;
            p_q       <= p_d;
            busy      <= busy_d;
            res_valid <= valid_d;
            ovr       <= ovr_d;
            // Capture the post-edge P so a same-cycle add or clear is included
            if (done) begin
                res_data <= p_d;
            end
        end
    end

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath (WIDTH = 16).
module tb_mult_datapath;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   data_in;
    logic           ld_a, ld_b, ld_p, clr, dec;
    logic           eqz, busy, res_valid, res_ready, ovr;
    logic [2*W-1:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    mult_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .ld_a(ld_a), .ld_b(ld_b), .ld_p(ld_p), .clr(clr), .dec(dec),
        .eqz(eqz), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_a = 0; ld_b = 0; ld_p = 0; clr = 0; dec = 0;
    endtask

    // Load A, then load B (optionally with clr), leaving strobes idle
    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic do_clr);
        idle(); ld_a = 1; data_in = a; step();
        idle(); ld_b = 1; clr = do_clr; data_in = b; step();
        idle();
    endtask

    task automatic test_reset();
        rst = 0; res_ready = 0; data_in = '0; idle();
        step(); step();
        n_checks++; if (eqz !== 1'b1) begin n_fail++; $display("FAIL reset_eqz: got %b expected 1", eqz); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
        n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", res_data); end
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
        rst = 1; step();
    endtask

    task automatic test_basic();
        int vcnt = 0;
        res_ready = 1;
        load(16'd3, 16'd4, 1'b1);
        n_checks++; if (busy !== 1'b1 || eqz !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_armed: busy=%b eqz=%b valid=%b expected 1 0 0", busy, eqz, res_valid); end
        ld_p = 1; dec = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (res_valid) vcnt++;
            n_checks++; if (eqz !== (i == 4) || res_valid !== (i == 4)) begin
                n_fail++; $display("FAIL basic_cycle%0d: eqz=%b valid=%b expected %b", i, eqz, res_valid, i == 4); end
        end
        idle();
        n_checks++; if (res_data !== 32'd12) begin n_fail++; $display("FAIL basic_data: got %0d expected 12", res_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy); end
        for (int i = 0; i < 3; i++) begin step(); if (res_valid) vcnt++; end
        n_checks++; if (vcnt != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d expected 1", vcnt); end
    endtask

    task automatic test_zero();
        int vcnt = 0;
        int bad_eqz = 0;
        res_ready = 1;
        load(16'd7, 16'd0, 1'b1);
        ld_p = 1; dec = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (res_valid) vcnt++;
            if (eqz !== 1'b1) bad_eqz++;
            if (i == 0) begin
                n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd0) begin
                    n_fail++; $display("FAIL zero_result: valid=%b data=%0d expected 1 0", res_valid, res_data); end
            end
        end
        idle(); step(); if (res_valid) vcnt++;
        n_checks++; if (vcnt != 1) begin n_fail++; $display("FAIL zero_valid_cycles: got %0d expected 1", vcnt); end
        n_checks++; if (bad_eqz != 0) begin n_fail++; $display("FAIL zero_eqz: %0d cycles with eqz low, expected 0", bad_eqz); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy); end
    endtask

    task automatic test_overrun();
        int vcnt = 0;
        res_ready = 1;
        load(16'd5, 16'd2, 1'b1);
        ld_p = 1; dec = 1;
        for (int i = 0; i < 5; i++) begin step(); if (res_valid) vcnt++; end
        idle(); step(); if (res_valid) vcnt++;
        n_checks++; if (vcnt != 1) begin n_fail++; $display("FAIL overrun_dones: got %0d expected 1", vcnt); end
        n_checks++; if (res_data !== 32'd10) begin n_fail++; $display("FAIL overrun_data: got %0d expected 10", res_data); end
        n_checks++; if (eqz !== 1'b1) begin n_fail++; $display("FAIL overrun_eqz: got %b expected 1", eqz); end
        // One more step without clr proves P held at 10 through the overrun
        ld_b = 1; data_in = 16'd1; step();
        idle(); ld_p = 1; dec = 1; step(); idle();
        n_checks++; if (res_data !== 32'd15 || res_valid !== 1'b1) begin
            n_fail++; $display("FAIL overrun_p_held: data=%0d valid=%b expected 15 1", res_data, res_valid); end
        step();
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        res_ready = 0;
        load(16'd2, 16'd3, 1'b1);
        ld_p = 1; dec = 1; repeat (3) step(); idle();
        n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd6 || ovr !== 1'b0) begin
            n_fail++; $display("FAIL bp_first: valid=%b data=%0d ovr=%b expected 1 6 0", res_valid, res_data, ovr); end
        repeat (3) begin step(); if (res_data !== 32'd6 || res_valid !== 1'b1) unstable++; end
        load(16'd4, 16'd4, 1'b1);
        ld_p = 1; dec = 1;
        repeat (3) begin step(); if (res_data !== 32'd6 || res_valid !== 1'b1) unstable++; end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable cycles, expected 0", unstable); end
        step(); idle();
        n_checks++; if (res_data !== 32'd16 || ovr !== 1'b1 || res_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_overwrite: data=%0d ovr=%b valid=%b expected 16 1 1", res_data, ovr, res_valid); end
        step();
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL bp_ovr_sticky: got %b expected 1", ovr); end
        clr = 1; step(); idle();
        n_checks++; if (ovr !== 1'b0 || res_data !== 32'd16) begin
            n_fail++; $display("FAIL bp_clr_ovr: ovr=%b data=%0d expected 0 16", ovr, res_data); end
        res_ready = 1; step();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        res_ready = 0;
        load(16'd3, 16'd2, 1'b1);
        ld_p = 1; dec = 1; repeat (2) step(); idle();
        n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd6) begin
            n_fail++; $display("FAIL b2b_first: valid=%b data=%0d expected 1 6", res_valid, res_data); end
        load(16'd5, 16'd1, 1'b1);
        ld_p = 1; dec = 1; res_ready = 1; step(); idle();
        n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd5 || ovr !== 1'b0) begin
            n_fail++; $display("FAIL b2b_swap: valid=%b data=%0d ovr=%b expected 1 5 0", res_valid, res_data, ovr); end
        step();
        n_checks++; if (res_valid !== 1'b0 || ovr !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: valid=%b ovr=%b expected 0 0", res_valid, ovr); end
    endtask

    task automatic test_reset_midrun();
        res_ready = 1;
        load(16'd9, 16'd6, 1'b1);
        ld_p = 1; dec = 1; repeat (2) step(); idle();
        #2 rst = 0; #1;
        n_checks++; if (res_valid !== 1'b0 || res_data !== 32'd0 || ovr !== 1'b0 || busy !== 1'b0 || eqz !== 1'b1) begin
            n_fail++; $display("FAIL midrun_reset: valid=%b data=%0d ovr=%b busy=%b eqz=%b expected 0 0 0 0 1",
                               res_valid, res_data, ovr, busy, eqz); end
        step(); rst = 1; step();
        load(16'd9, 16'd6, 1'b1);
        ld_p = 1; dec = 1; repeat (5) step();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_early: got %b expected 0", res_valid); end
        step(); idle();
        n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd54) begin
            n_fail++; $display("FAIL midrun_rerun: valid=%b data=%0d expected 1 54", res_valid, res_data); end
        step();
    endtask

    task automatic test_max();
        res_ready = 1;
        // Squaring: A and B loaded from the same bus value in one cycle
        idle(); ld_a = 1; ld_b = 1; clr = 1; data_in = 16'hFFFF; step(); idle();
        ld_p = 1; dec = 1;
        repeat (65534) step();
        n_checks++; if (eqz !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL max_before: eqz=%b valid=%b expected 0 0", eqz, res_valid); end
        step(); idle();
        n_checks++; if (res_valid !== 1'b1 || res_data !== 32'hFFFE0001 || eqz !== 1'b1) begin
            n_fail++; $display("FAIL max_result: valid=%b data=%h eqz=%b expected 1 fffe0001 1", res_valid, res_data, eqz); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overrun();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
